// File: rtl/ot_soc_top.sv
// rtl/ot_soc_top.sv - boot/bring-up SoC top: UART boot loader into program memory, UART echo, GPIO status
// Holds the 8N1 receiver and transmitter used by the top as local modules.

module ot_uart_rx #(
    parameter int ClksPerBit = 87
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data
);
    localparam int CW = $clog2(ClksPerBit + 1);
    localparam logic [CW-1:0] LastCnt = CW'(ClksPerBit - 1);
    localparam logic [CW-1:0] HalfCnt = CW'(ClksPerBit / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e       r_state, w_next;
    logic [1:0]      r_sync;
    logic            r_prev;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_valid;
    logic            w_rx;
    logic            w_tick;

    assign w_rx    = r_sync[1];
    assign o_valid = r_valid;
    assign o_data  = r_shift;

    always_comb begin
        w_next = r_state;
        w_tick = 1'b0;
        case (r_state)
            RX_IDLE:  if (r_prev && !w_rx) w_next = RX_START;
            RX_START: if (r_cnt == HalfCnt) begin
                w_tick = 1'b1;
                w_next = w_rx ? RX_IDLE : RX_DATA;
            end
            RX_DATA:  if (r_cnt == LastCnt) begin
                w_tick = 1'b1;
                if (r_bit == 3'd7) w_next = RX_STOP;
            end
            RX_STOP:  if (r_cnt == LastCnt) begin
                w_tick = 1'b1;
                w_next = RX_IDLE;
            end
            default:  w_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rx};
            r_prev  <= w_rx;
            r_state <= w_next;
            r_valid <= 1'b0;
            r_cnt   <= (r_state == RX_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
            if (r_state == RX_START) r_bit <= '0;
            if (r_state == RX_DATA && w_tick) begin
                r_shift <= {w_rx, r_shift[7:1]};
                r_bit   <= r_bit + 1'b1;
            end
            // a low stop bit is a framing error: the byte is simply never flagged
            if (r_state == RX_STOP && w_tick) r_valid <= w_rx;
        end
    end
endmodule

module ot_uart_tx #(
    parameter int ClksPerBit = 87
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);
    localparam int CW = $clog2(ClksPerBit + 1);
    localparam logic [CW-1:0] LastCnt = CW'(ClksPerBit - 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

    tx_state_e     r_state, w_next;
    logic [8:0]    r_shift;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bitn;
    logic          r_tx;
    logic          w_tick;

    assign w_tick  = (r_cnt == LastCnt);
    assign o_ready = (r_state == TX_IDLE);
    assign o_tx    = r_tx;

    always_comb begin
        w_next = r_state;
        case (r_state)
            TX_IDLE: if (i_valid) w_next = TX_SEND;
            TX_SEND: if (w_tick && r_bitn == 4'd9) w_next = TX_IDLE;
            default: w_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= TX_IDLE;
            r_shift <= '1;
            r_cnt   <= '0;
            r_bitn  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == TX_IDLE) begin
                r_cnt  <= '0;
                r_bitn <= '0;
                if (i_valid) begin
                    r_tx    <= 1'b0;
                    r_shift <= {1'b1, i_data};
                end
            end else if (w_tick) begin
                r_cnt <= '0;
                if (r_bitn != 4'd9) begin
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                    r_bitn  <= r_bitn + 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

module ot_soc_top #(
    parameter logic [31:0] JTAG_ID      = 32'h0000_0001,
    parameter bit          DirectDmiTap = 1'b1,
    parameter int          ClkFreq      = 10_000_000,
    parameter int          BaudRate     = 115_200,
    parameter int          MemWords     = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        uart_rx_i,
    input  logic        uart_rx,
    output logic        uart_tx,
    input  logic [19:0] gpio_i,
    output logic [19:0] gpio_o
);
    localparam int ClksPerBit = ClkFreq / BaudRate + 1;
    localparam int AW         = $clog2(MemWords);

    logic          w_b_valid, w_r_valid, w_tx_ready, w_unused;
    logic [7:0]    w_b_data, w_r_data;
    logic          r_boot_done, r_hold_full;
    logic [AW:0]   r_wr_ptr;
    logic [1:0]    r_bcnt;
    logic [23:0]   r_word;
    logic [7:0]    r_last, r_hold;
    logic [31:0]   r_mem [MemWords];
    logic [31:0]   r_rd;
    logic [19:0]   r_gpio;

    ot_uart_rx #(.ClksPerBit(ClksPerBit)) u_boot_rx (
        .clk_i(clk_i), .rst_ni(rst_ni), .i_rx(uart_rx_i), .o_valid(w_b_valid), .o_data(w_b_data));
    ot_uart_rx #(.ClksPerBit(ClksPerBit)) u_run_rx (
        .clk_i(clk_i), .rst_ni(rst_ni), .i_rx(uart_rx), .o_valid(w_r_valid), .o_data(w_r_data));

    logic        w_r_ok, w_tx_valid;
    logic [7:0]  w_tx_data;
    assign w_r_ok     = w_r_valid & r_boot_done;
    assign w_tx_valid = r_hold_full | w_r_ok;
    assign w_tx_data  = r_hold_full ? r_hold : w_r_data;

    ot_uart_tx #(.ClksPerBit(ClksPerBit)) u_tx (
        .clk_i(clk_i), .rst_ni(rst_ni), .i_valid(w_tx_valid), .i_data(w_tx_data),
        .o_ready(w_tx_ready), .o_tx(uart_tx));

    logic        w_boot_byte, w_word_done, w_sentinel, w_mem_we, w_done_nxt;
    logic [31:0] w_word;
    logic [AW:0] w_ptr_nxt;
    logic [7:0]  w_last_nxt;
    logic [11:0] w_ptr_ext;

    assign w_boot_byte = w_b_valid & ~r_boot_done;
    assign w_word_done = w_boot_byte & (r_bcnt == 2'd3);
    assign w_word      = {w_b_data, r_word};
    assign w_sentinel  = (w_word == 32'h0000_0FFF);
    assign w_mem_we    = w_word_done & ~w_sentinel & (r_wr_ptr != (AW+1)'(MemWords));
    assign w_ptr_nxt   = r_wr_ptr + (AW+1)'(w_mem_we);
    assign w_last_nxt  = w_boot_byte ? w_b_data : r_last;
    assign w_done_nxt  = r_boot_done | (w_word_done & w_sentinel);
    assign w_ptr_ext   = 12'(w_ptr_nxt);
    assign gpio_o      = r_gpio;
    assign w_unused    = ^{JTAG_ID, DirectDmiTap, gpio_i[19:AW], w_ptr_ext[11]};

    always_ff @(posedge clk_i) begin
        if (w_mem_we) r_mem[r_wr_ptr[AW-1:0]] <= w_word;
        r_rd <= r_mem[gpio_i[AW-1:0]];
    end

    // status is built from next-state values so it moves in the same clock as wr_ptr/boot_done
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_boot_done <= 1'b0;
            r_wr_ptr    <= '0;
            r_bcnt      <= '0;
            r_word      <= '0;
            r_last      <= '0;
            r_gpio      <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_boot_done <= w_done_nxt;
            r_wr_ptr    <= w_ptr_nxt;
            r_last      <= w_last_nxt;
            if (w_boot_byte) begin
                r_bcnt <= r_bcnt + 1'b1;
                r_word <= {w_b_data, r_word[23:8]};
            end
            r_gpio <= w_done_nxt ? {4'b1000, r_rd[15:0]} : {1'b0, w_ptr_ext[10:0], w_last_nxt};
            if (r_hold_full) begin
                if (w_tx_ready) begin
                    if (w_r_ok) r_hold <= w_r_data;
                    else        r_hold_full <= 1'b0;
                end
            end else if (w_r_ok && !w_tx_ready) begin
                r_hold      <= w_r_data;
                r_hold_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ot_soc_top.sv
// tb/tb_ot_soc_top.sv - self-checking bench for ot_soc_top against a byte/word level boot and echo model

module tb_ot_soc_top;
    localparam int CPB = 10_000_000 / 115_200 + 1;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        uart_rx_i;
    logic        uart_rx;
    logic        uart_tx;
    logic [19:0] gpio_i;
    logic [19:0] gpio_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_mem[$];
    logic [7:0]  m_bytes[$];
    logic [7:0]  m_last;
    logic        m_done;

    ot_soc_top dut (
        .clk_i(clk), .rst_ni(rst_ni), .uart_rx_i(uart_rx_i), .uart_rx(uart_rx),
        .uart_tx(uart_tx), .gpio_i(gpio_i), .gpio_o(gpio_o));

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_mem.delete();
        m_bytes.delete();
        m_last = 8'h00;
        m_done = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [31:0] w;
        if (m_done) return;
        m_last = b;
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
            w = m_bytes[0] + (m_bytes[1] * 256) + (m_bytes[2] * 65536) + (m_bytes[3] * 16777216);
            m_bytes.delete();
            if (w == 32'h0000_0FFF) m_done = 1'b1;
            else if (m_mem.size() < 1024) m_mem.push_back(w);
        end
    endtask

    function automatic logic [19:0] boot_status();
        return {1'b0, 11'(m_mem.size()), m_last};
    endfunction

    task automatic set_line(input int ch, input logic v);
        if (ch == 0) uart_rx_i = v;
        else         uart_rx   = v;
    endtask

    task automatic send_byte(input int ch, input logic [7:0] b, input logic stop_bit);
        set_line(ch, 1'b0);
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            set_line(ch, b[i]);
            tick(CPB);
        end
        set_line(ch, stop_bit);
        tick(CPB);
        set_line(ch, 1'b1);
    endtask

    task automatic boot_byte(input logic [7:0] b);
        send_byte(0, b, 1'b1);
        model_byte(b);
    endtask

    task automatic capture_tx(output logic [9:0] f, output bit ok);
        int t = 0;
        f  = '0;
        ok = 1'b1;
        while (uart_tx !== 1'b0 && t < 25 * CPB) begin
            tick(1);
            t++;
        end
        if (uart_tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        tick(CPB / 2);
        f[0] = uart_tx;
        for (int i = 1; i < 10; i++) begin
            tick(CPB);
            f[i] = uart_tx;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; uart_rx_i = 1'b1; uart_rx = 1'b1; gpio_i = '0;
        model_reset();
        tick(4);
        rst_ni = 1'b1;
        tick(2);
        n_cmp++;
        if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
        n_cmp++;
        if (gpio_o !== 20'h00000) begin n_bad++; $display("FAIL reset_gpio: got %h expected 00000", gpio_o); end
    endtask

    task automatic test_boot_word();
        boot_byte(8'h13); boot_byte(8'h01); boot_byte(8'h20); boot_byte(8'h00);
        tick(4);
        n_cmp++;
        if (gpio_o !== boot_status()) begin n_bad++; $display("FAIL boot_word: got %h expected %h", gpio_o, boot_status()); end
        n_cmp++;
        if (m_mem[0] !== 32'h0020_0113 || gpio_o[18:8] !== 11'd1) begin
            n_bad++; $display("FAIL boot_word_ptr: got %h expected ptr 1", gpio_o);
        end
    endtask

    task automatic test_glitch();
        uart_rx_i = 1'b0;
        tick(10);
        uart_rx_i = 1'b1;
        tick(12 * CPB);
        n_cmp++;
        if (gpio_o !== boot_status()) begin n_bad++; $display("FAIL glitch: got %h expected %h", gpio_o, boot_status()); end
    endtask

    task automatic test_framing();
        send_byte(0, 8'h5A, 1'b0);
        tick(3 * CPB);
        n_cmp++;
        if (gpio_o !== boot_status()) begin n_bad++; $display("FAIL framing_drop: got %h expected %h", gpio_o, boot_status()); end
        boot_byte(8'h77);
        tick(4);
        n_cmp++;
        if (gpio_o !== boot_status()) begin n_bad++; $display("FAIL framing_next: got %h expected %h", gpio_o, boot_status()); end
        for (int i = 0; i < 3; i++) boot_byte(8'($urandom));
        tick(4);
        n_cmp++;
        if (gpio_o !== boot_status()) begin n_bad++; $display("FAIL framing_word: got %h expected %h", gpio_o, boot_status()); end
    endtask

    task automatic test_reset_mid_byte();
        boot_byte(8'h3C);
        uart_rx_i = 1'b0;
        tick(3 * CPB + 20);
        rst_ni = 1'b0;
        uart_rx_i = 1'b1;
        model_reset();
        tick(2);
        n_cmp++;
        if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL midreset_tx: got %b expected 1", uart_tx); end
        n_cmp++;
        if (gpio_o !== 20'h00000) begin n_bad++; $display("FAIL midreset_gpio: got %h expected 00000", gpio_o); end
        rst_ni = 1'b1;
        tick(5);
        boot_byte(8'h13); boot_byte(8'h01); boot_byte(8'h20); boot_byte(8'h00);
        tick(4);
        n_cmp++;
        if (gpio_o !== boot_status()) begin n_bad++; $display("FAIL midreset_word: got %h expected %h", gpio_o, boot_status()); end
    endtask

    task automatic test_boot_random();
        int k = $urandom_range(3, 5);
        logic [31:0] w;
        for (int n = 0; n < k; n++) begin
            do w = $urandom; while (w == 32'h0000_0FFF);
            for (int i = 0; i < 4; i++) boot_byte(w[8*i +: 8]);
            tick(4);
            n_cmp++;
            if (gpio_o !== boot_status()) begin n_bad++; $display("FAIL boot_rand_%0d: got %h expected %h", n, gpio_o, boot_status()); end
        end
        boot_byte(8'hFF); boot_byte(8'h0F); boot_byte(8'h00);
        tick(4);
        n_cmp++;
        if (gpio_o[18:8] !== 11'(m_mem.size())) begin
            n_bad++; $display("FAIL sentinel_ptr: got %0d expected %0d", gpio_o[18:8], m_mem.size());
        end
        boot_byte(8'h00);
        tick(4);
        n_cmp++;
        if (gpio_o[19:16] !== {m_done, 3'b000}) begin
            n_bad++; $display("FAIL sentinel_done: got %h expected %h", gpio_o[19:16], {m_done, 3'b000});
        end
    endtask

    task automatic test_readback();
        logic [15:0] prev;
        for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom), 1'b1);
        gpio_i = 20'h0;
        tick(3);
        prev = m_mem[0][15:0];
        for (int i = m_mem.size() - 1; i >= 0; i--) begin
            gpio_i = {9'($urandom), 11'(i)};
            tick(1);
            if (m_mem[i][15:0] != prev) begin
                n_cmp++;
                if (gpio_o[15:0] !== prev) begin n_bad++; $display("FAIL rb_latency_%0d: got %h expected %h", i, gpio_o[15:0], prev); end
            end
            tick(1);
            n_cmp++;
            if (gpio_o !== {4'b1000, m_mem[i][15:0]}) begin
                n_bad++; $display("FAIL readback_%0d: got %h expected %h", i, gpio_o, {4'b1000, m_mem[i][15:0]});
            end
            prev = m_mem[i][15:0];
        end
        n_cmp++;
        if (gpio_o[15:0] !== 16'h0113) begin n_bad++; $display("FAIL readback_word0: got %h expected 0113", gpio_o[15:0]); end
    endtask

    task automatic test_echo();
        logic [9:0] f;
        bit ok;
        fork
            send_byte(1, 8'hA5, 1'b1);
            capture_tx(f, ok);
        join
        n_cmp++;
        if (!ok || f !== 10'b1_10100101_0) begin n_bad++; $display("FAIL echo_a5: got %b ok=%0d expected %b", f, ok, 10'b1_10100101_0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[2];
        logic [9:0] f[2];
        bit ok[2];
        b[0] = 8'($urandom); b[1] = 8'($urandom);
        tick(2 * CPB);
        fork
            begin send_byte(1, b[0], 1'b1); send_byte(1, b[1], 1'b1); end
            begin capture_tx(f[0], ok[0]); capture_tx(f[1], ok[1]); end
        join
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (!ok[i] || f[i] !== {1'b1, b[i], 1'b0}) begin
                n_bad++; $display("FAIL b2b_%0d: got %b ok=%0d expected %b", i, f[i], ok[i], {1'b1, b[i], 1'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_boot_word();
        test_glitch();
        test_framing();
        test_reset_mid_byte();
        test_boot_random();
        test_readback();
        test_echo();
        test_back_to_back();
        tick(CPB);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
